// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect,
// multi-cycle MUL/DIV occupancy and data-memory wait states with timeout.
module hazard_controller #(
   parameter int MD_LATENCY  = 4,
   parameter int MEM_TIMEOUT = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_RegisterRd,
   input  logic [4:0]       IF_ID_RegisterRs1,
   input  logic [4:0]       IF_ID_RegisterRs2,
   input  logic             ID_EX_MulDiv,
   input  logic             branch_taken,
   input  logic             EX_MEM_MemReq,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             md_done,
   output logic             mem_err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int MDW = (MD_LATENCY  > 1) ? $clog2(MD_LATENCY + 1)  : 1;
   localparam int MTW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MD_BUSY  = 2'b01,
      MEM_WAIT = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [MDW-1:0]   md_cnt_q, md_cnt_d;
   logic [MTW-1:0]   mem_cnt_q, mem_cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             load_use;

   assign load_use = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                     ((ID_EX_RegisterRd == IF_ID_RegisterRs1) ||
                      (ID_EX_RegisterRd == IF_ID_RegisterRs2));

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      md_done      = 1'b0;
      mem_err      = 1'b0;
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;
      mem_cnt_d    = mem_cnt_q;
      if (!rst_n) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_flush = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (EX_MEM_MemReq && !mem_ready) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_en    = 1'b0;
                  mem_wb_flush = 1'b1;
                  mem_cnt_d    = MTW'(1);
                  state_d      = MEM_WAIT;
               end else if (branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (ID_EX_MulDiv) begin
                  if (MD_LATENCY > 1) begin
                     pc_en        = 1'b0;
                     if_id_en     = 1'b0;
                     id_ex_en     = 1'b0;
                     ex_mem_flush = 1'b1;
                     md_cnt_d     = MDW'(MD_LATENCY - 1);
                     state_d      = MD_BUSY;
                  end else begin
                     md_done = 1'b1;
                  end
               end else if (load_use) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            MD_BUSY: begin
               if (md_cnt_q == MDW'(1)) begin
                  md_done = 1'b1;
                  state_d = RUN;
               end else begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_flush = 1'b1;
                  md_cnt_d     = md_cnt_q - MDW'(1);
               end
            end
            MEM_WAIT: begin
               // a same-cycle ready beats the timeout
               if (mem_ready) begin
                  state_d = RUN;
               end else if (mem_cnt_q == MTW'(MEM_TIMEOUT)) begin
                  mem_err = 1'b1;
                  state_d = RUN;
               end else begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_en    = 1'b0;
                  mem_wb_flush = 1'b1;
                  mem_cnt_d    = mem_cnt_q + MTW'(1);
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (!pc_en && (stall_q != {CNT_W{1'b1}}))
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= RUN;
         md_cnt_q  <= '0;
         mem_cnt_q <= '0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         md_cnt_q  <= md_cnt_d;
         mem_cnt_q <= mem_cnt_d;
         stall_q   <= stall_d;
      end
   end

   assign state        = state_q;
   assign stall_cycles = stall_q;

endmodule
